// File: rtl/eth_frame_tx.sv
// eth_frame_tx: end-device serial frame transmitter.
// Host requests {dest, payload} enter a small FIFO through a valid/ready
// port. Each request becomes one frame {SFD, dest, MAC_ADDRESS, payload}.
// The frame goes out MSB-first on tx_bit, and an idle gap follows it.
// Optional feature macro: ETH_TX_STATS_EN adds the tx_frame_cnt port, a
// 16-bit wrapping count of frames sent.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high. req_ready depends only on the registered queue
// count. It has no combinational path from req_valid or from the pop side,
// so a full queue keeps ready low even in a cycle that pops.
module eth_frame_tx #(
    parameter int                    DEPTH       = 16,
    parameter int                    ADDR_WIDTH  = 4,
    parameter logic [ADDR_WIDTH-1:0] MAC_ADDRESS = 4'h1,
    parameter logic [3:0]            SFD         = 4'hD,
    parameter int                    IFG_CYCLES  = 4,
    parameter int                    QUEUE_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [ADDR_WIDTH-1:0]             req_dest,
    input  logic [DEPTH-4-2*ADDR_WIDTH-1:0]   req_payload,
    output logic                              tx_bit,
    output logic                              tx_busy,
    output logic                              frame_done
`ifdef ETH_TX_STATS_EN
    ,
    output logic [15:0]                       tx_frame_cnt
`endif
);

    localparam int PW    = DEPTH - 4 - 2 * ADDR_WIDTH;
    localparam int EW    = ADDR_WIDTH + PW;
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DEPTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    // The FSM state is a plain named register so checkers can bind to it.
    state_t state;

    logic [EW-1:0]    mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [DEPTH-1:0] shreg;
    logic [BIT_W-1:0] bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             push;
    logic             pop;
    logic             has_work;
    logic [EW-1:0]    head;

    assign req_ready = (count != FULL_CNT);
    assign push      = req_valid && req_ready;
    // The head is consumed in the single LOAD cycle of every frame.
    assign pop       = (state == LOAD);
    // An entry being pushed this edge can be loaded on the very next edge.
    // This lets an idle transmitter reach LOAD one cycle after acceptance.
    assign has_work  = (count != '0) || push;
    assign head      = mem[rd_ptr];

    // Queue storage write; contents need no reset because count gates use.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req_dest, req_payload};
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Transmit FSM: load a frame, shift it out MSB-first, then hold the idle gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            tx_bit     <= 1'b0;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx_bit <= 1'b0;
                    if (has_work) begin
                        state   <= LOAD;
                        tx_busy <= 1'b1;
                    end
                end
                LOAD: begin
                    tx_bit  <= 1'b0;
                    shreg   <= {SFD, head[EW-1:PW], MAC_ADDRESS, head[PW-1:0]};
                    bit_cnt <= BIT_LAST;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    tx_bit <= shreg[DEPTH-1];
                    shreg  <= {shreg[DEPTH-2:0], 1'b0};
                    if (bit_cnt == '0) begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                GAP: begin
                    tx_bit <= 1'b0;
                    // The first GAP edge retires the last bit from the line.
                    // The done pulse is therefore visible right after that edge.
                    frame_done <= (gap_cnt == '0);
                    if (gap_cnt == GAP_LAST) begin
                        if (has_work) begin
                            state <= LOAD;
                        end else begin
                            state   <= IDLE;
                            tx_busy <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef ETH_TX_STATS_EN
    // Frame counter advances on each done pulse and wraps at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_frame_cnt <= '0;
        end else if (frame_done) begin
            tx_frame_cnt <= tx_frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_eth_frame_tx.sv
// Directed testbench for eth_frame_tx with default parameters.
// The bench has a clock and reset block, and driver tasks.
// A serial receiver model decodes tx_bit into frames with their start cycles.
// A scoreboard compares received frames against an expected queue.
module tb_eth_frame_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_dest = 4'h0;
    logic [3:0]  req_payload = 4'h0;
    logic        tx_bit;
    logic        tx_busy;
    logic        frame_done;
`ifdef ETH_TX_STATS_EN
    logic [15:0] tx_frame_cnt;
`endif

    eth_frame_tx dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_dest    (req_dest),
        .req_payload (req_payload),
        .tx_bit      (tx_bit),
        .tx_busy     (tx_busy),
        .frame_done  (frame_done)
`ifdef ETH_TX_STATS_EN
        ,
        .tx_frame_cnt(tx_frame_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // ---------------- receiver model ----------------
    // Line idles at 0 and every frame starts with SFD MSB = 1.
    // Sampled 1 time unit after each rising edge; cyc is the edge number.
    int          cyc = 0;
    int          rx_n = 0;
    int          rx_start = 0;
    logic [15:0] rx_sh = '0;
    logic [15:0] got_q[$];
    int          got_t[$];
    logic [15:0] exp_q[$];

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (rst) begin
            rx_n = 0;
        end else begin
            if (rx_n == 0) begin
                if (tx_bit === 1'b1) begin
                    rx_sh    = 16'h0001;
                    rx_n     = 1;
                    rx_start = cyc;
                end
            end else begin
                rx_sh = {rx_sh[14:0], tx_bit};
                rx_n  = rx_n + 1;
            end
            if (rx_n == 16) begin
                got_q.push_back(rx_sh);
                got_t.push_back(rx_start);
                rx_n = 0;
            end
        end
    end

    // ---------------- drivers ----------------
    int acc_cyc = 0;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Present one request and hold it until accepted (bounded).
    task automatic push(input logic [3:0] d, input logic [3:0] p);
        int t;
        t = 0;
        req_valid   = 1'b1;
        req_dest    = d;
        req_payload = p;
        while (!req_ready && t < 100) begin
            step();
            t++;
        end
        if (t == 100) check("push_timeout", 0, 1);
        step();
        acc_cyc   = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t;
        t = 0;
        while (got_q.size() < n && t < budget) begin
            step();
            t++;
        end
    endtask

    // Scoreboard: every expected frame must arrive, in order.
    task automatic drain(input string tag, input int budget);
        wait_frames(exp_q.size(), budget);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            check(tag, got_q.pop_front(), exp_q.pop_front());
        end
        exp_q.delete();
        got_q.delete();
        got_t.delete();
    endtask

    function automatic int t_at(input int i);
        return (i < got_t.size()) ? got_t[i] : -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        got_q.delete();
        got_t.delete();
        exp_q.delete();
    endtask

    // ---------------- directed vectors ----------------
    logic [3:0]  t2_d[6] = '{4'h2, 4'h4, 4'h7, 4'h8, 4'hE, 4'h5};
    logic [3:0]  t2_p[6] = '{4'h5, 4'h6, 4'h9, 4'h0, 4'hF, 4'h3};
    logic [15:0] t2_f[6] = '{16'hD215, 16'hD416, 16'hD719, 16'hD810, 16'hDE1F, 16'hD513};

    initial begin
        int e;
        int acc;
        int t;
        int acc_t[6];
        bit full_seen;
        logic rdy;

        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_tx_bit", tx_bit, 0);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_req_ready", req_ready, 1);
        step();
        step();
        rst = 1'b0;
        step();

        // Test 1: single frame, exact latency
        exp_q.push_back(16'hD31A);
        push(4'h3, 4'hA);
        e = acc_cyc;
        step();
        check("t1_busy_load", tx_busy, 1);
        check("t1_line_load", tx_bit, 0);
        repeat (16) step();
        check("t1_done_early", frame_done, 0);
        step();
        check("t1_frame_done", frame_done, 1);
        check("t1_line_gap", tx_bit, 0);
        step();
        check("t1_done_pulse", frame_done, 0);
        check("t1_sfd_time", t_at(0), e + 2);
        drain("t1_frame", 50);
        repeat (5) step();
        check("t1_idle_busy", tx_busy, 0);

        // Test 2: six requests back-to-back, queue fills, strict order and spacing
        acc = 0;
        t = 0;
        full_seen = 1'b0;
        req_valid   = 1'b1;
        req_dest    = t2_d[0];
        req_payload = t2_p[0];
        while (acc < 6 && t < 300) begin
            rdy = req_ready;
            step();
            t++;
            if (rdy) begin
                acc_t[acc] = cyc;
                exp_q.push_back(t2_f[acc]);
                acc++;
                if (acc < 6) begin
                    req_dest    = t2_d[acc];
                    req_payload = t2_p[acc];
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (acc == 5 && !full_seen) begin
                full_seen = 1'b1;
                check("t2_ready_full", req_ready, 0);
            end
        end
        req_valid = 1'b0;
        check("t2_all_accepted", acc, 6);
        check("t2_fifth_accept", acc_t[4], acc_t[0] + 4);
        check("t2_ready_recover", acc_t[5], acc_t[0] + 23);
        wait_frames(6, 200);
        check("t2_first_sfd", t_at(0), acc_t[0] + 2);
        for (int i = 1; i < 6; i++) begin
            check("t2_spacing", t_at(i) - t_at(i - 1), 21);
        end
        drain("t2_frame", 50);
        repeat (8) step();

        // Test 3: broadcast and own-MAC destinations pass through untouched
        exp_q.push_back(16'hDF12);
        exp_q.push_back(16'hD11C);
        push(4'hF, 4'h2);
        push(4'h1, 4'hC);
        wait_frames(2, 100);
        if (got_q.size() >= 2) begin
            check("t3_dest_bcast", got_q[0][11:8], 4'hF);
            check("t3_dest_own", got_q[1][11:8], 4'h1);
        end else begin
            check("t3_frames_seen", got_q.size(), 2);
        end
        drain("t3_frame", 50);
        repeat (8) step();

        // Test 4: reset mid-frame with a full queue
        push(4'h3, 4'h8);
        e = acc_cyc;
        push(4'h5, 4'h1);
        push(4'h6, 4'h2);
        push(4'h7, 4'h3);
        push(4'h9, 4'h4);
        while (cyc < e + 9) step();
        check("t4_bit7_pre", tx_bit, 1);
        check("t4_ready_full_pre", req_ready, 0);
        rst = 1'b1;
        #1;
        check("t4_rst_line", tx_bit, 0);
        check("t4_rst_ready", req_ready, 1);
        check("t4_rst_busy", tx_busy, 0);
        step();
        step();
        rst = 1'b0;
        got_q.delete();
        got_t.delete();
        repeat (60) step();
        check("t4_no_frames", got_q.size(), 0);
        check("t4_no_bits", rx_n, 0);
        check("t4_idle_busy", tx_busy, 0);
        exp_q.push_back(16'hD617);
        push(4'h6, 4'h7);
        drain("t4_after", 50);
        repeat (8) step();

`ifdef ETH_TX_STATS_EN
        // Test 6: frame counter and its wrap
        do_reset();
        check("t6_cnt_reset", tx_frame_cnt, 0);
        exp_q.push_back(16'hD211);
        exp_q.push_back(16'hD312);
        exp_q.push_back(16'hD413);
        push(4'h2, 4'h1);
        push(4'h3, 4'h2);
        push(4'h4, 4'h3);
        drain("t6_frame", 150);
        repeat (6) step();
        check("t6_cnt_three", tx_frame_cnt, 3);
        force dut.tx_frame_cnt = 16'hFFFF;
        step();
        release dut.tx_frame_cnt;
        step();
        exp_q.push_back(16'hD514);
        push(4'h5, 4'h4);
        drain("t6_wrap_frame", 50);
        repeat (6) step();
        check("t6_cnt_wrap", tx_frame_cnt, 0);
`else
        do_reset();
        check("final_rst_busy", tx_busy, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
